rx_frame_deserializer: RTL
==========================

// Module: rx_frame_deserializer
// PURPOSE
//  UART receive stage directly downstream of the start-bit detector. On a DeStart_Bit pulse it
//  samples DATA_BITS data bits (LSB first), an optional parity bit and one stop bit from Rx_In,
//  using OVERSAMPLE Baud_Clk ticks per bit with a 3-sample majority vote at mid-bit. It then
//  presents the received byte with parity/framing status and a one-cycle Rx_Done strobe.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..9)
//  PARITY_EN   1   1 = parity bit follows data; 0 = no parity bit, Parity_Err tied 0
//  PARITY_ODD  0   0 = even parity expected, 1 = odd parity expected
//  OVERSAMPLE  16  Baud_Clk ticks per bit; must be >= 4; tick counter width $clog2(OVERSAMPLE)
// PORTS
//  Baud_Clk    in   1          oversampling clock; all state changes on its rising edge
//  Rst_n       in   1          asynchronous, active-low reset
//  Rx_In       in   1          serial line, idle high
//  DeStart_Bit in   1          one-cycle pulse from the start-bit detector: start bit has ended
//  Rx_Data     out  DATA_BITS  last received data word, bit 0 = first bit on the line
//  Rx_Done     out  1          one-cycle strobe: Rx_Data/Parity_Err/Frame_Err updated this cycle
//  Parity_Err  out  1          parity mismatch for the last frame
//  Frame_Err   out  1          stop bit voted low for the last frame
//  Rx_Busy     out  1          high from the cycle after DeStart_Bit accepted until Rx_Done
// BEHAVIOUR
//  - Reset (async, Rst_n=0): state IDLE, tick=0, bit index=0, shift reg=0; Rx_Data=0,
//    Rx_Done=0, Parity_Err=0, Frame_Err=0, Rx_Busy=0. Reset mid-frame aborts the frame
//    with no Rx_Done.
//  - States: IDLE -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//  - IDLE: DeStart_Bit=1 at edge E0 -> DATA, tick=0, bit index=0, Rx_Busy=1.
//    DeStart_Bit is ignored in every other state.
//  - Tick counter increments on each edge, wraps OVERSAMPLE-1 -> 0. Samples taken at edges
//    where tick == M-1, M, M+1 (M = OVERSAMPLE/2). Bit value = majority (2 of 3).
//  - DATA: at edge with tick == OVERSAMPLE-1, shift voted bit in from the MSB side (right
//    shift) so the first bit lands in bit 0 after DATA_BITS shifts. Increment bit index;
//    after DATA_BITS bits, go to PARITY (PARITY_EN=1) or STOP.
//  - PARITY: vote as above; hold the voted bit p; at tick == OVERSAMPLE-1 go to STOP.
//  - STOP: at edge with tick == M+1 (third sample included in vote), in one edge:
//    Rx_Data <= shift reg; Frame_Err <= ~stop_vote;
//    Parity_Err <= PARITY_EN & (^data ^ p ^ PARITY_ODD); Rx_Done <= 1; Rx_Busy <= 0;
//    state <= IDLE. Remainder of the stop bit is left to the start detector.
//  - Rx_Done is high for exactly one cycle. Rx_Data, Parity_Err and Frame_Err hold until
//    the next Rx_Done or reset. Data is delivered even when Frame_Err=1 or Parity_Err=1.
//  - Latency (OVERSAMPLE=16, DATA_BITS=8), counting E0 as the DeStart_Bit edge: bit n
//    sampled at E16n+8..E16n+10. Rx_Done high after E154 (parity) or E138 (no parity).
//  - DeStart_Bit in the same cycle Rx_Done is asserted is accepted (state is IDLE
//    after that edge only if the pulse arrives on a later edge). Back-to-back frames need
//    no idle gap beyond what the detector imposes.
// TESTING
//  1 Frame 0x55, even parity bit 0, stop 1 -> Rx_Done at E154, Rx_Data=0x55,
//    Parity_Err=0, Frame_Err=0.
//  2 Frame 0xA3 with parity bit 1 (PARITY_ODD=0) -> Rx_Data=0xA3, Parity_Err=1, Frame_Err=0.
//  3 Frame 0x0F with stop bit driven 0 -> Rx_Data=0x0F, Frame_Err=1, Rx_Done still one cycle.
//  4 Frame 0xFF with a single-tick low glitch at tick M of bit 3 -> majority rejects it,
//    Rx_Data=0xFF; two-tick glitch (M, M+1) -> Rx_Data=0xF7.
//  5 Rst_n pulsed low during bit 4 -> all outputs 0 immediately, no Rx_Done;
//    next clean frame 0x3C -> Rx_Data=0x3C.
//  6 Extra DeStart_Bit pulse during DATA ignored; back-to-back 0x12 then 0x34
//    -> two Rx_Done strobes with the correct data.

Source files
------------

// File: rtl/rx_frame_deserializer.sv
// rx_frame_deserializer: oversampled UART frame receiver (data, optional parity, stop) with 3-sample majority vote
module rx_frame_deserializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 Baud_Clk,
   input  logic                 Rst_n,
   input  logic                 Rx_In,
   input  logic                 DeStart_Bit,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Rx_Done,
   output logic                 Parity_Err,
   output logic                 Frame_Err,
   output logic                 Rx_Busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int M  = OVERSAMPLE / 2;
   localparam logic [TW-1:0] T_LO  = TW'(M - 1);
   localparam logic [TW-1:0] T_MID = TW'(M);
   localparam logic [TW-1:0] T_HI  = TW'(M + 1);
   localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t               state;
   logic [TW-1:0]        tick;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 s_lo, s_mid, vote_q, par, maj, vote;

   // majority of the two stored samples and the live third one; the held vote covers the bit end
   always_comb begin
      maj  = (s_lo & s_mid) | (s_lo & Rx_In) | (s_mid & Rx_In);
      vote = (tick == T_HI) ? maj : vote_q;
   end

   // capture the mid-bit samples and the finished vote
   always_ff @(posedge Baud_Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s_lo   <= 1'b0;
         s_mid  <= 1'b0;
         vote_q <= 1'b0;
      end else begin
         if (tick == T_LO)  s_lo   <= Rx_In;
         if (tick == T_MID) s_mid  <= Rx_In;
         if (tick == T_HI)  vote_q <= maj;
      end
   end

   // frame sequencer with registered outputs
   always_ff @(posedge Baud_Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         par        <= 1'b0;
         Rx_Data    <= '0;
         Rx_Done    <= 1'b0;
         Parity_Err <= 1'b0;
         Frame_Err  <= 1'b0;
         Rx_Busy    <= 1'b0;
      end else begin
         Rx_Done <= 1'b0;
         tick    <= (state == IDLE || tick == T_END) ? '0 : tick + 1'b1;
         case (state)
            IDLE: if (DeStart_Bit) begin
               state   <= DATA;
               bit_idx <= '0;
               Rx_Busy <= 1'b1;
            end
            DATA: if (tick == T_END) begin
               shift   <= {vote, shift[DATA_BITS-1:1]};
               bit_idx <= bit_idx + 1'b1;
               if (bit_idx == B_END) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (tick == T_END) begin
               par   <= vote;
               state <= STOP;
            end
            STOP: if (tick == T_HI) begin
               Rx_Data    <= shift;
               Frame_Err  <= ~maj;
               Parity_Err <= (PARITY_EN != 0) & (^shift ^ par ^ (PARITY_ODD != 0));
               Rx_Done    <= 1'b1;
               Rx_Busy    <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
